// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared types and constants for the GPR writeback arbiter.
package gpr_pkg;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_GPR = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] wd;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

  function automatic logic [NUM_GPR-1:0] rd_onehot(input logic [ADDR_W-1:0] r);
    logic [NUM_GPR-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback request handshakes, GPR write port and pending-register mask.
interface gpr_wb_arbiter_if;

  logic                        alu_valid;
  logic                        alu_ready;
  logic [gpr_pkg::ADDR_W-1:0]  alu_rd;
  logic [gpr_pkg::DATA_W-1:0]  alu_wd;
  logic                        mem_valid;
  logic                        mem_ready;
  logic [gpr_pkg::ADDR_W-1:0]  mem_rd;
  logic [gpr_pkg::DATA_W-1:0]  mem_wd;
  logic                        wGPR;
  logic [gpr_pkg::ADDR_W-1:0]  rd;
  logic [gpr_pkg::DATA_W-1:0]  wd;
  logic [gpr_pkg::NUM_GPR-1:0] pend_mask;

  modport master (
    output alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
    input  alu_ready, mem_ready, wGPR, rd, wd, pend_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd, mem_valid, mem_rd, mem_wd,
    output alu_ready, mem_ready, wGPR, rd, wd, pend_mask
  );

endinterface

// File: rtl/gpr_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO of writeback requests; exposes every slot and its
// validity so the owner can build a pending-register mask.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_req_t                din_i,
  input  logic                   pop_i,
  output wb_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output wb_req_t [DEPTH-1:0]    entries_o,
  output logic    [DEPTH-1:0]    entry_valid_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                do_push;
  logic                do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;

  // Slot gi holds live data when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic [PTR_W-1:0] offs;
      assign offs              = PTR_W'(gi) - rd_ptr_q;
      assign entry_valid_o[gi] = (CNT_W'(offs) < count_q);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin merge of ALU and load writebacks onto the single registered
// GPR write port, with a mask of destinations still in flight.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  gpr_wb_arbiter_if.slave  bus
);

  wb_req_t                  alu_req, mem_req, alu_head, mem_head, grant_req;
  wb_req_t [FIFO_DEPTH-1:0] alu_entries, mem_entries;
  logic    [FIFO_DEPTH-1:0] alu_ev, mem_ev;
  logic                     alu_full, alu_empty, mem_full, mem_empty;
  logic                     alu_push, mem_push, alu_pop, mem_pop;
  logic                     grant_valid;
  src_t                     grant_src;

  logic                     wgpr_q, wgpr_d;
  logic [ADDR_W-1:0]        rd_q, rd_d;
  logic [DATA_W-1:0]        wd_q, wd_d;
  src_t                     last_grant_q, last_grant_d;
  logic [NUM_GPR-1:0]       pend_mask;

  assign alu_req = '{rd: bus.alu_rd, wd: bus.alu_wd};
  assign mem_req = '{rd: bus.mem_rd, wd: bus.mem_wd};

  // Writes to r0 complete the handshake but are never buffered.
  assign alu_push = bus.alu_valid && !alu_full && (bus.alu_rd != '0);
  assign mem_push = bus.mem_valid && !mem_full && (bus.mem_rd != '0);

  assign bus.alu_ready = !alu_full;
  assign bus.mem_ready = !mem_full;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (alu_push),
    .din_i         (alu_req),
    .pop_i         (alu_pop),
    .head_o        (alu_head),
    .full_o        (alu_full),
    .empty_o       (alu_empty),
    .entries_o     (alu_entries),
    .entry_valid_o (alu_ev)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (mem_push),
    .din_i         (mem_req),
    .pop_i         (mem_pop),
    .head_o        (mem_head),
    .full_o        (mem_full),
    .empty_o       (mem_empty),
    .entries_o     (mem_entries),
    .entry_valid_o (mem_ev)
  );

  always_comb begin
    grant_valid  = !alu_empty || !mem_empty;
    grant_src    = SRC_ALU;
    if (!alu_empty && !mem_empty) begin
      grant_src = (last_grant_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (!mem_empty) begin
      grant_src = SRC_MEM;
    end
    alu_pop      = grant_valid && (grant_src == SRC_ALU);
    mem_pop      = grant_valid && (grant_src == SRC_MEM);
    grant_req    = (grant_src == SRC_MEM) ? mem_head : alu_head;

    wgpr_d       = grant_valid;
    rd_d         = rd_q;
    wd_d         = wd_q;
    last_grant_d = last_grant_q;
    if (grant_valid) begin
      rd_d         = grant_req.rd;
      wd_d         = grant_req.wd;
      last_grant_d = grant_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wgpr_q       <= 1'b0;
      rd_q         <= '0;
      wd_q         <= '0;
      last_grant_q <= SRC_ALU;
    end else begin
      wgpr_q       <= wgpr_d;
      rd_q         <= rd_d;
      wd_q         <= wd_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_ev[i]) pend_mask = pend_mask | rd_onehot(alu_entries[i].rd);
      if (mem_ev[i]) pend_mask = pend_mask | rd_onehot(mem_entries[i].rd);
    end
    if (wgpr_q) pend_mask = pend_mask | rd_onehot(rd_q);
    pend_mask[0] = 1'b0;
  end

  assign bus.wGPR      = wgpr_q;
  assign bus.rd        = rd_q;
  assign bus.wd        = wd_q;
  assign bus.pend_mask = pend_mask;

endmodule
